fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences the team's dual-port `ram` block as a synchronous FIFO. Owns the write/read pointers, occupancy count, status flags and error flags, and drives the RAM's write/read enables and addresses. The data bus runs directly from the producer to `ram.wrdata`, and from `ram.rddata` to the consumer. `rd_valid` marks the cycle in which `ram.rddata` holds the popped word. The top-level `sync_fifo` ties `wrclk` and `rdclk` to `clk`, and drives `ram.rst_n` from `~rst`.

---
 rtl/fifo_ctrl_pkg.sv | 14 +
 rtl/fifo_ptr.sv | 22 ++
 rtl/fifo_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and width helpers for the FIFO controller and its pointer sub-module.
package fifo_ctrl_pkg;

  localparam int unsigned DEF_ADDR_BIT   = 9;
  localparam int unsigned DEF_ADDR_DEPTH = 512;
  localparam int unsigned DEF_AFULL_TH   = 480;
  localparam int unsigned DEF_AEMPTY_TH  = 32;

  // Pointers and occupancy carry one extra bit so that full and empty are distinguishable.
  function automatic int unsigned count_width(input int unsigned addr_bit);
    return addr_bit + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with increment enable, synchronous clear and asynchronous reset.
module fifo_ptr #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller sequencing a dual-port RAM: pointers, occupancy, status and
// sticky error flags.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BIT   = DEF_ADDR_BIT,
  parameter int unsigned ADDR_DEPTH = DEF_ADDR_DEPTH,
  parameter int unsigned AFULL_TH   = DEF_AFULL_TH,
  parameter int unsigned AEMPTY_TH  = DEF_AEMPTY_TH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic                clr_err,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_BIT:0]   count,
  output logic                overflow,
  output logic                underflow,
  output logic                rd_valid,
  output logic                ram_wren,
  output logic [ADDR_BIT-1:0] ram_wraddress,
  output logic                ram_rden,
  output logic [ADDR_BIT-1:0] ram_rdaddress
);

  localparam int unsigned CW = count_width(ADDR_BIT);
  localparam logic [CW-1:0] DEPTH_C  = CW'(ADDR_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  if (ADDR_DEPTH != (1 << ADDR_BIT)) begin : g_bad_depth
    $error("fifo_ctrl: ADDR_DEPTH must equal 2**ADDR_BIT");
  end
  if (AEMPTY_TH >= AFULL_TH) begin : g_bad_thresh
    $error("fifo_ctrl: AEMPTY_TH must be below AFULL_TH");
  end

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;
  logic          overflow_set;
  logic          underflow_set;

  // A push into a full FIFO is still taken when a pop frees the slot on the same edge.
  assign pop_ok        = pop & ~flush & ~empty;
  assign push_ok       = push & ~flush & (~full | pop_ok);
  assign overflow_set  = push & ~flush & ~push_ok;
  assign underflow_set = pop & ~flush & ~pop_ok;

  assign ram_wren      = push_ok;
  assign ram_rden      = pop_ok;
  assign ram_wraddress = wr_ptr[ADDR_BIT-1:0];
  assign ram_rdaddress = rd_ptr[ADDR_BIT-1:0];

  fifo_ptr #(
    .W(CW)
  ) u_wr_ptr (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .inc(push_ok),
    .ptr(wr_ptr)
  );

  fifo_ptr #(
    .W(CW)
  ) u_rd_ptr (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .inc(pop_ok),
    .ptr(rd_ptr)
  );

  always_comb begin
    count_d = count;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Flags are derived from the next count so they move on the same edge as count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      count        <= count_d;
      full         <= (count_d == DEPTH_C);
      empty        <= (count_d == '0);
      almost_full  <= (count_d >= AFULL_C);
      almost_empty <= (count_d <= AEMPTY_C);
      overflow     <= overflow_set | (overflow & ~clr_err);
      underflow    <= underflow_set | (underflow & ~clr_err);
      rd_valid     <= pop_ok;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with an 8-entry behavioural RAM on the data path.
module tb_fifo_ctrl;

  localparam int unsigned AB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic          full, empty, almost_full, almost_empty;
  logic [AB:0]   count;
  logic          overflow, underflow, rd_valid;
  logic          ram_wren, ram_rden;
  logic [AB-1:0] ram_wraddress, ram_rdaddress;
  logic [7:0]    wrdata = 8'h00;
  logic [7:0]    rddata;
  logic [7:0]    mem [0:7];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .ADDR_BIT  (AB),
    .ADDR_DEPTH(8),
    .AFULL_TH  (6),
    .AEMPTY_TH (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .flush        (flush),
    .clr_err      (clr_err),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .rd_valid     (rd_valid),
    .ram_wren     (ram_wren),
    .ram_wraddress(ram_wraddress),
    .ram_rden     (ram_rden),
    .ram_rdaddress(ram_rdaddress)
  );

  // Read sees pre-write contents when both ports hit the same address on one edge.
  always_ff @(posedge clk) begin
    if (ram_wren) mem[ram_wraddress] <= wrdata;
    if (ram_rden) rddata <= mem[ram_rdaddress];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_flags(input string tag);
    check({tag, " count"}, count, 0);
    check({tag, " empty"}, empty, 1);
    check({tag, " almost_empty"}, almost_empty, 1);
    check({tag, " full"}, full, 0);
    check({tag, " almost_full"}, almost_full, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " underflow"}, underflow, 0);
    check({tag, " rd_valid"}, rd_valid, 0);
  endtask

  logic [7:0] drain_exp [0:7];

  initial begin
    drain_exp[0] = 8'h12; drain_exp[1] = 8'h13; drain_exp[2] = 8'h14; drain_exp[3] = 8'h15;
    drain_exp[4] = 8'h16; drain_exp[5] = 8'h17; drain_exp[6] = 8'h18; drain_exp[7] = 8'h99;

    #23 rst = 1'b0;
    check_idle_flags("reset");

    // Pop while empty
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("pop_empty underflow", underflow, 1);
    check("pop_empty rd_valid", rd_valid, 0);
    check("pop_empty count", count, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr_err underflow", underflow, 0);

    // Fill with 0x11..0x18
    for (int i = 0; i < 8; i++) begin
      push   = 1'b1;
      wrdata = 8'h11 + 8'(i);
      step();
      check($sformatf("fill%0d count", i), count, i + 1);
      check($sformatf("fill%0d almost_empty", i), almost_empty, (i + 1 <= 1) ? 1 : 0);
      check($sformatf("fill%0d almost_full", i), almost_full, (i + 1 >= 6) ? 1 : 0);
      check($sformatf("fill%0d full", i), full, (i + 1 == 8) ? 1 : 0);
      check($sformatf("fill%0d wraddress", i), ram_wraddress, (i + 1) % 8);
    end
    push = 1'b0;

    // Ninth push alone overflows
    push   = 1'b1;
    wrdata = 8'hEE;
    #1 check("push_full wren", ram_wren, 0);
    step();
    push = 1'b0;
    check("push_full overflow", overflow, 1);
    check("push_full count", count, 8);
    check("push_full full", full, 1);

    // Push and pop together while full
    push   = 1'b1;
    pop    = 1'b1;
    wrdata = 8'h99;
    #1 check("full_pp wren", ram_wren, 1);
    step();
    push = 1'b0;
    check("full_pp rd_valid", rd_valid, 1);
    check("full_pp rddata", rddata, 8'h11);
    check("full_pp count", count, 8);
    check("full_pp full", full, 1);

    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("drain%0d rd_valid", i), rd_valid, 1);
      check($sformatf("drain%0d rddata", i), rddata, drain_exp[i]);
    end
    pop = 1'b0;
    check("drained empty", empty, 1);
    check("drained count", count, 0);
    step();
    check("idle rd_valid", rd_valid, 0);

    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("clr overflow", overflow, 0);

    // Push and pop together while empty
    push   = 1'b1;
    pop    = 1'b1;
    wrdata = 8'h5A;
    step();
    push = 1'b0;
    check("empty_pp underflow", underflow, 1);
    check("empty_pp count", count, 1);
    check("empty_pp rd_valid", rd_valid, 0);
    check("empty_pp empty", empty, 0);
    step();
    pop = 1'b0;
    check("after_pp rd_valid", rd_valid, 1);
    check("after_pp rddata", rddata, 8'h5A);
    check("after_pp count", count, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Reach count 5 with a pop in flight, then flush with push and pop
    for (int i = 0; i < 6; i++) begin
      push   = 1'b1;
      wrdata = 8'h21 + 8'(i);
      step();
    end
    push = 1'b0;
    pop  = 1'b1;
    step();
    check("pre_flush count", count, 5);
    check("pre_flush rd_valid", rd_valid, 1);
    push  = 1'b1;
    flush = 1'b1;
    #1 check("flush wren", ram_wren, 0);
    check("flush rden", ram_rden, 0);
    step();
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    check_idle_flags("flush");
    check("flush wraddress", ram_wraddress, 0);

    // Asynchronous reset mid-cycle at count 3
    for (int i = 0; i < 3; i++) begin
      push   = 1'b1;
      wrdata = 8'h31 + 8'(i);
      step();
    end
    push = 1'b0;
    check("pre_rst count", count, 3);
    check("pre_rst almost_empty", almost_empty, 0);
    #2 rst = 1'b1;
    #1 check_idle_flags("async_rst");
    check("async_rst wraddress", ram_wraddress, 0);
    #3 rst = 1'b0;
    step();
    check("post_rst count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
